ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the datapath width in bits.
REQ-002 SHALL have clk input 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have reset input 1: synchronous, active-high reset.
REQ-004 SHALL have flush_e input 1: inserts a bubble into the ID/EX register.
REQ-005 SHALL have rd1_d and rd2_d inputs WIDTH: register-file read data from decode.
REQ-006 SHALL have rs_d, rt_d and rd_d inputs 5: register specifiers from decode.
REQ-007 SHALL have signimm_d input WIDTH: sign-extended immediate.
REQ-008 SHALL have regwrite_d, memtoreg_d, memwrite_d, alusrc_d and regdst_d inputs 1: decode control bits.
REQ-009 SHALL have alucontrol_d input 3: ALU operation select.
REQ-010 SHALL have forward_a and forward_b inputs 2: operand source selects from the hazard unit.
REQ-011 SHALL have result_w input WIDTH: writeback-stage result.
REQ-012 SHALL have rs_e and rt_e outputs 5: registered specifiers returned to the hazard unit.
REQ-013 SHALL have writereg_e output 5, plus regwrite_e and memtoreg_e outputs 1: EX-stage destination and control for hazard detection.
REQ-014 SHALL have regwrite_m, memtoreg_m and memwrite_m outputs 1: EX/MEM control bits.
REQ-015 SHALL have writereg_m output 5: EX/MEM destination register.
REQ-016 SHALL have aluout_m and writedata_m outputs WIDTH: EX/MEM ALU result and store data.

Function
REQ-017 SHALL hold an ID/EX register capturing all *_d inputs each cycle.
REQ-018 SHALL clear every ID/EX field to zero on a cycle with flush_e=1, giving a bubble with regwrite_e=0 and memwrite_e=0.
REQ-019 SHALL give flush_e priority over capture when both apply in the same cycle.
REQ-020 SHALL select operand srca_e per forward_a: 00 means rd1_e, 01 means result_w, 10 means aluout_m, 11 means rd1_e.
REQ-021 SHALL select writedata_e per forward_b using the same encoding, applied to rd2_e.
REQ-022 SHALL set srcb_e to signimm_e when alusrc_e=1, otherwise to writedata_e.
REQ-023 SHALL compute the ALU result combinationally per alucontrol_e: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed, result 1 or 0).
REQ-024 SHALL produce zero for unused alucontrol_e codes.
REQ-025 SHALL perform ADD and SUB modulo 2^WIDTH with no overflow trap.
REQ-026 SHALL set writereg_e to rd_e when regdst_e=1, otherwise to rt_e.
REQ-027 SHALL capture, in the EX/MEM register each cycle, the ALU result, writedata_e, writereg_e and the control bits into the *_m outputs.
REQ-028 SHALL have a latency of one cycle from the ID/EX register to the *_m outputs, and two cycles from *_d inputs to *_m outputs.
REQ-029 SHALL advance a flush arriving mid-stream the existing EX contents into EX/MEM normally; only ID/EX is cleared.
REQ-030 SHALL use the aluout_m value present before the clock edge for forwarding (back-to-back dependency without stall).

Reset
REQ-031 SHALL, on a rising edge with reset=1, clear every ID/EX and EX/MEM field, so all outputs read zero the next cycle.
REQ-032 SHALL give reset priority over flush_e and normal capture, including reset asserted mid-stream.

Structure
REQ-033 SHALL place the ALU opcode constants (AND, OR, ADD, SUB, SLT) in the shared MIPS package, and the forward-select encodings in the same package.
REQ-034 SHALL implement the ALU as the one natural sub-module, named alu, which is purely combinational.

Verification
REQ-035 SHALL cover a basic path: add with rd1_d=5, rd2_d=7, alusrc=0, forward=00 -> aluout_m=12 two cycles later.
REQ-036 SHALL cover MEM forwarding: forward_a=10 with aluout_m=0x100 and rd1_e=0 -> next aluout_m=0x100+srcb.
REQ-037 SHALL cover WB forwarding and select 11: forward_b=01 with result_w=0xDEAD -> writedata_m=0xDEAD; forward_b=11 -> writedata_m=rd2_e.
REQ-038 SHALL cover SLT sign handling: srca=0xFFFFFFFF, srcb=1 -> aluout_m=1; sub 3-5 -> 0xFFFFFFFE.
REQ-039 SHALL cover a flush/reset bubble: flush_e=1 during a regwrite instruction -> regwrite_e=0 and one cycle later regwrite_m=0 and writereg_m=0; reset mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared MIPS pipeline constants: ALU opcodes, forwarding selects and EX control bundle.
package ex_stage_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // 11 is a legal but redundant encoding that also selects the register file.
   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_WB     = 2'b01;
   localparam logic [1:0] FWD_MEM    = 2'b10;
   localparam logic [1:0] FWD_RF_ALT = 2'b11;

   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regdst;
      logic [2:0] alucontrol;
   } ex_ctrl_t;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
      logic memwrite;
   } mem_ctrl_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Purely combinational MIPS ALU; unused opcodes yield zero, arithmetic wraps.
module alu
   import ex_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alucontrol,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (alucontrol)
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, operand forwarding, ALU and EX/MEM register.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_e,
   input  logic [WIDTH-1:0] rd1_d,
   input  logic [WIDTH-1:0] rd2_d,
   input  logic [4:0]       rs_d,
   input  logic [4:0]       rt_d,
   input  logic [4:0]       rd_d,
   input  logic [WIDTH-1:0] signimm_d,
   input  logic             regwrite_d,
   input  logic             memtoreg_d,
   input  logic             memwrite_d,
   input  logic             alusrc_d,
   input  logic             regdst_d,
   input  logic [2:0]       alucontrol_d,
   input  logic [1:0]       forward_a,
   input  logic [1:0]       forward_b,
   input  logic [WIDTH-1:0] result_w,
   output logic [4:0]       rs_e,
   output logic [4:0]       rt_e,
   output logic [4:0]       writereg_e,
   output logic             regwrite_e,
   output logic             memtoreg_e,
   output logic             regwrite_m,
   output logic             memtoreg_m,
   output logic             memwrite_m,
   output logic [4:0]       writereg_m,
   output logic [WIDTH-1:0] aluout_m,
   output logic [WIDTH-1:0] writedata_m
);

   logic [WIDTH-1:0] rd1_e_q, rd1_e_d;
   logic [WIDTH-1:0] rd2_e_q, rd2_e_d;
   logic [WIDTH-1:0] imm_e_q, imm_e_d;
   logic [4:0]       rs_e_q, rs_e_d;
   logic [4:0]       rt_e_q, rt_e_d;
   logic [4:0]       rd_e_q, rd_e_d;
   ex_ctrl_t         ctrl_e_q, ctrl_e_d;

   logic [WIDTH-1:0] aluout_m_q, aluout_m_d;
   logic [WIDTH-1:0] writedata_m_q, writedata_m_d;
   logic [4:0]       writereg_m_q, writereg_m_d;
   mem_ctrl_t        ctrl_m_q, ctrl_m_d;

   logic [WIDTH-1:0] srca_e, srcb_e, writedata_e, aluresult_e;
   logic [4:0]       writereg_e_int;

   function automatic logic [WIDTH-1:0] fwd_mux(
      input logic [1:0]       sel,
      input logic [WIDTH-1:0] from_rf,
      input logic [WIDTH-1:0] from_wb,
      input logic [WIDTH-1:0] from_mem
   );
      case (sel)
         FWD_WB:  return from_wb;
         FWD_MEM: return from_mem;
         default: return from_rf;
      endcase
   endfunction

   // A flush loads an all-zero bubble, which is a harmless AND into r0.
   always_comb begin
      rd1_e_d  = rd1_d;
      rd2_e_d  = rd2_d;
      imm_e_d  = signimm_d;
      rs_e_d   = rs_d;
      rt_e_d   = rt_d;
      rd_e_d   = rd_d;
      ctrl_e_d = '{regwrite: regwrite_d, memtoreg: memtoreg_d, memwrite: memwrite_d,
                   alusrc: alusrc_d, regdst: regdst_d, alucontrol: alucontrol_d};
      if (flush_e) begin
         rd1_e_d  = '0;
         rd2_e_d  = '0;
         imm_e_d  = '0;
         rs_e_d   = '0;
         rt_e_d   = '0;
         rd_e_d   = '0;
         ctrl_e_d = '0;
      end
   end

   // aluout_m_q is the pre-edge value, so a dependent back-to-back op needs no stall.
   always_comb begin
      srca_e         = fwd_mux(forward_a, rd1_e_q, result_w, aluout_m_q);
      writedata_e    = fwd_mux(forward_b, rd2_e_q, result_w, aluout_m_q);
      srcb_e         = ctrl_e_q.alusrc ? imm_e_q : writedata_e;
      writereg_e_int = ctrl_e_q.regdst ? rd_e_q : rt_e_q;
   end

   alu #(.WIDTH(WIDTH)) u_alu (
      .a          (srca_e),
      .b          (srcb_e),
      .alucontrol (ctrl_e_q.alucontrol),
      .y          (aluresult_e)
   );

   always_comb begin
      aluout_m_d    = aluresult_e;
      writedata_m_d = writedata_e;
      writereg_m_d  = writereg_e_int;
      ctrl_m_d      = '{regwrite: ctrl_e_q.regwrite, memtoreg: ctrl_e_q.memtoreg,
                        memwrite: ctrl_e_q.memwrite};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd1_e_q       <= '0;
         rd2_e_q       <= '0;
         imm_e_q       <= '0;
         rs_e_q        <= '0;
         rt_e_q        <= '0;
         rd_e_q        <= '0;
         ctrl_e_q      <= '0;
         aluout_m_q    <= '0;
         writedata_m_q <= '0;
         writereg_m_q  <= '0;
         ctrl_m_q      <= '0;
      end else begin
         rd1_e_q       <= rd1_e_d;
         rd2_e_q       <= rd2_e_d;
         imm_e_q       <= imm_e_d;
         rs_e_q        <= rs_e_d;
         rt_e_q        <= rt_e_d;
         rd_e_q        <= rd_e_d;
         ctrl_e_q      <= ctrl_e_d;
         aluout_m_q    <= aluout_m_d;
         writedata_m_q <= writedata_m_d;
         writereg_m_q  <= writereg_m_d;
         ctrl_m_q      <= ctrl_m_d;
      end
   end

   assign rs_e        = rs_e_q;
   assign rt_e        = rt_e_q;
   assign writereg_e  = writereg_e_int;
   assign regwrite_e  = ctrl_e_q.regwrite;
   assign memtoreg_e  = ctrl_e_q.memtoreg;
   assign regwrite_m  = ctrl_m_q.regwrite;
   assign memtoreg_m  = ctrl_m_q.memtoreg;
   assign memwrite_m  = ctrl_m_q.memwrite;
   assign writereg_m  = writereg_m_q;
   assign aluout_m    = aluout_m_q;
   assign writedata_m = writedata_m_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_ex_stage;

   localparam int W = 32;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        regwrite;
      logic        memtoreg;
      logic        memwrite;
      logic        alusrc;
      logic        regdst;
      logic [2:0]  op;
   } instr_t;

   logic          clk = 1'b0;
   logic          reset, flush_e;
   logic [W-1:0]  rd1_d, rd2_d, signimm_d, result_w;
   logic [4:0]    rs_d, rt_d, rd_d;
   logic          regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
   logic [2:0]    alucontrol_d;
   logic [1:0]    forward_a, forward_b;
   logic [4:0]    rs_e, rt_e, writereg_e, writereg_m;
   logic          regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, memwrite_m;
   logic [W-1:0]  aluout_m, writedata_m;

   always #5 clk = ~clk;

   ex_stage #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .flush_e(flush_e),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
      .signimm_d(signimm_d), .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d),
      .memwrite_d(memwrite_d), .alusrc_d(alusrc_d), .regdst_d(regdst_d),
      .alucontrol_d(alucontrol_d), .forward_a(forward_a), .forward_b(forward_b),
      .result_w(result_w), .rs_e(rs_e), .rt_e(rt_e), .writereg_e(writereg_e),
      .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .regwrite_m(regwrite_m),
      .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m), .writereg_m(writereg_m),
      .aluout_m(aluout_m), .writedata_m(writedata_m)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   // Reference state: the instruction sitting in EX and the expected EX/MEM contents.
   instr_t      ex_m;
   logic [31:0] aluout_x, wd_x;
   logic [4:0]  wr_x;
   logic        rwm_x, mtrm_x, mwm_x;

   localparam instr_t NOP = '0;

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a + b;
         3'd6: return a - b;
         3'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_pick(input logic [1:0] s, input logic [31:0] rf,
                                            input logic [31:0] wb, input logic [31:0] mem);
      if (s == 2'd1) return wb;
      if (s == 2'd2) return mem;
      return rf;
   endfunction

   function automatic instr_t mk(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic [31:0] imm, input logic alusrc, input logic rw,
                                 input logic regdst, input logic [4:0] rt, input logic [4:0] rd);
      instr_t i;
      i          = '0;
      i.op       = op;
      i.rd1      = rd1;
      i.rd2      = rd2;
      i.imm      = imm;
      i.alusrc   = alusrc;
      i.regwrite = rw;
      i.regdst   = regdst;
      i.rt       = rt;
      i.rd       = rd;
      i.rs       = 5'd1;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i.rd1      = $urandom;
      i.rd2      = $urandom;
      i.imm      = ($urandom_range(0, 1) == 1) ? 32'($signed($urandom_range(0, 65535) - 32768)) : $urandom;
      i.rs       = 5'($urandom_range(0, 31));
      i.rt       = 5'($urandom_range(0, 31));
      i.rd       = 5'($urandom_range(0, 31));
      i.regwrite = 1'($urandom_range(0, 1));
      i.memtoreg = 1'($urandom_range(0, 1));
      i.memwrite = 1'($urandom_range(0, 1));
      i.alusrc   = 1'($urandom_range(0, 1));
      i.regdst   = 1'($urandom_range(0, 1));
      i.op       = 3'($urandom_range(0, 7));
      return i;
   endfunction

   // Applies one clock of stimulus and advances the reference model by the same edge.
   task automatic cycle(input instr_t in, input logic fl, input logic rst,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rwv);
      logic [31:0] a, wd, b;
      reset = rst; flush_e = fl; forward_a = fa; forward_b = fb; result_w = rwv;
      rd1_d = in.rd1; rd2_d = in.rd2; signimm_d = in.imm;
      rs_d = in.rs; rt_d = in.rt; rd_d = in.rd;
      regwrite_d = in.regwrite; memtoreg_d = in.memtoreg; memwrite_d = in.memwrite;
      alusrc_d = in.alusrc; regdst_d = in.regdst; alucontrol_d = in.op;
      a  = ref_pick(fa, ex_m.rd1, rwv, aluout_x);
      wd = ref_pick(fb, ex_m.rd2, rwv, aluout_x);
      b  = ex_m.alusrc ? ex_m.imm : wd;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         ex_m = '0; aluout_x = '0; wd_x = '0; wr_x = '0; rwm_x = 0; mtrm_x = 0; mwm_x = 0;
      end else begin
         aluout_x = ref_alu(ex_m.op, a, b);
         wd_x     = wd;
         wr_x     = ex_m.regdst ? ex_m.rd : ex_m.rt;
         rwm_x    = ex_m.regwrite;
         mtrm_x   = ex_m.memtoreg;
         mwm_x    = ex_m.memwrite;
         ex_m     = fl ? NOP : in;
      end
      $display("[TB] cyc %0d rst=%0b fl=%0b fa=%0d fb=%0d op_d=%0d aluout_m=%h writedata_m=%h writereg_m=%0d",
               cyc, rst, fl, fa, fb, in.op, aluout_m, writedata_m, writereg_m);
   endtask

   task automatic test_reset();
      cycle(rand_instr(), 1'b0, 1'b1, 2'd0, 2'd0, 32'h0);
      cycle(rand_instr(), 1'b1, 1'b1, 2'd2, 2'd1, 32'h1234);
      tests_run++;
      if ({rs_e, rt_e, writereg_e, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, memwrite_m,
           writereg_m, aluout_m, writedata_m} !== '0) begin
         tests_failed++;
         $display("FAIL reset_state aluout_m=%h writedata_m=%h writereg_m=%0d rs_e=%0d rt_e=%0d required all zero",
                  aluout_m, writedata_m, writereg_m, rs_e, rt_e);
      end
   endtask

   task automatic test_basic_add();
      cycle(mk(3'd2, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b1, 5'd2, 5'd3), 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      cycle(NOP, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      tests_run++;
      if (aluout_m !== 32'd12) begin
         tests_failed++;
         $display("FAIL basic_add aluout_m got %h required %h", aluout_m, 32'd12);
      end
      tests_run++;
      if (writereg_m !== 5'd3 || regwrite_m !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_add_dest writereg_m=%0d regwrite_m=%0b required 3/1", writereg_m, regwrite_m);
      end
   endtask

   task automatic test_mem_forward();
      cycle(mk(3'd2, 32'h80, 32'h80, 32'd0, 1'b0, 1'b1, 1'b0, 5'd4, 5'd0), 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      cycle(mk(3'd2, 32'h0, 32'h23, 32'd0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0), 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      tests_run++;
      if (aluout_m !== 32'h100) begin
         tests_failed++;
         $display("FAIL mem_fwd_producer aluout_m got %h required %h", aluout_m, 32'h100);
      end
      cycle(NOP, 1'b0, 1'b0, 2'd2, 2'd0, 32'h0);
      tests_run++;
      if (aluout_m !== 32'h123) begin
         tests_failed++;
         $display("FAIL mem_fwd aluout_m got %h required %h", aluout_m, 32'h123);
      end
   endtask

   task automatic test_wb_forward();
      cycle(mk(3'd2, 32'h1, 32'h55, 32'd0, 1'b0, 1'b0, 1'b0, 5'd6, 5'd0), 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      cycle(mk(3'd0, 32'h1, 32'h77, 32'd0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0), 1'b0, 1'b0, 2'd0, 2'd1, 32'hDEAD);
      tests_run++;
      if (writedata_m !== 32'hDEAD) begin
         tests_failed++;
         $display("FAIL wb_fwd writedata_m got %h required %h", writedata_m, 32'hDEAD);
      end
      cycle(NOP, 1'b0, 1'b0, 2'd0, 2'd3, 32'hBEEF);
      tests_run++;
      if (writedata_m !== 32'h77) begin
         tests_failed++;
         $display("FAIL fwd_sel11 writedata_m got %h required %h", writedata_m, 32'h77);
      end
   endtask

   task automatic test_slt_sub();
      cycle(mk(3'd7, 32'hFFFF_FFFF, 32'h0, 32'd1, 1'b1, 1'b1, 1'b1, 5'd0, 5'd8), 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      cycle(mk(3'd6, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd9), 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      tests_run++;
      if (aluout_m !== 32'd1) begin
         tests_failed++;
         $display("FAIL slt_signed aluout_m got %h required %h", aluout_m, 32'd1);
      end
      cycle(mk(3'd3, 32'hF, 32'hF, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0), 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      tests_run++;
      if (aluout_m !== 32'hFFFF_FFFE) begin
         tests_failed++;
         $display("FAIL sub_wrap aluout_m got %h required %h", aluout_m, 32'hFFFF_FFFE);
      end
      cycle(NOP, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      tests_run++;
      if (aluout_m !== 32'd0) begin
         tests_failed++;
         $display("FAIL unused_op aluout_m got %h required %h", aluout_m, 32'd0);
      end
   endtask

   task automatic test_flush();
      cycle(mk(3'd2, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd9), 1'b1, 1'b0, 2'd0, 2'd0, 32'h0);
      tests_run++;
      if (regwrite_e !== 1'b0 || writereg_e !== 5'd0) begin
         tests_failed++;
         $display("FAIL flush_bubble_e regwrite_e=%0b writereg_e=%0d required 0/0", regwrite_e, writereg_e);
      end
      cycle(NOP, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      tests_run++;
      if (regwrite_m !== 1'b0 || writereg_m !== 5'd0) begin
         tests_failed++;
         $display("FAIL flush_bubble_m regwrite_m=%0b writereg_m=%0d required 0/0", regwrite_m, writereg_m);
      end
      // A flush mid-stream must still let the older instruction reach EX/MEM.
      cycle(mk(3'd1, 32'h0F, 32'hF0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd2, 5'd7), 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      cycle(mk(3'd2, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1, 5'd2, 5'd11), 1'b1, 1'b0, 2'd0, 2'd0, 32'h0);
      tests_run++;
      if (regwrite_m !== 1'b1 || writereg_m !== 5'd7 || aluout_m !== 32'hFF || regwrite_e !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_midstream regwrite_m=%0b writereg_m=%0d aluout_m=%h regwrite_e=%0b required 1/7/ff/0",
                  regwrite_m, writereg_m, aluout_m, regwrite_e);
      end
   endtask

   task automatic test_reset_midstream();
      cycle(rand_instr(), 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
      cycle(rand_instr(), 1'b0, 1'b0, 2'd1, 2'd2, $urandom);
      cycle(rand_instr(), 1'b1, 1'b1, 2'd2, 2'd1, $urandom);
      tests_run++;
      if ({rs_e, rt_e, writereg_e, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, memwrite_m,
           writereg_m, aluout_m, writedata_m} !== '0) begin
         tests_failed++;
         $display("FAIL reset_midstream aluout_m=%h writedata_m=%h writereg_m=%0d regwrite_m=%0b required all zero",
                  aluout_m, writedata_m, writereg_m, regwrite_m);
      end
   endtask

   task automatic test_random(input int n);
      logic [68:0] got, exp;
      for (int k = 0; k < n; k++) begin
         cycle(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
         got = {rs_e, rt_e, writereg_e, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, memwrite_m, writereg_m};
         exp = {5'(ex_m.rs), 5'(ex_m.rt), (ex_m.regdst ? ex_m.rd : ex_m.rt), ex_m.regwrite, ex_m.memtoreg,
                rwm_x, mtrm_x, mwm_x, wr_x};
         tests_run++;
         if (got[24:0] !== exp[24:0] || aluout_m !== aluout_x || writedata_m !== wd_x) begin
            tests_failed++;
            $display("FAIL random_%0d ctl=%h aluout_m=%h writedata_m=%h required ctl=%h aluout_m=%h writedata_m=%h",
                     k, got[24:0], aluout_m, writedata_m, exp[24:0], aluout_x, wd_x);
         end
      end
   endtask

   initial begin
      ex_m = '0; aluout_x = '0; wd_x = '0; wr_x = '0; rwm_x = 0; mtrm_x = 0; mwm_x = 0;
      test_reset();
      test_basic_add();
      test_mem_forward();
      test_wb_forward();
      test_slt_sub();
      test_flush();
      test_reset_midstream();
      test_random(300);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
